// File: rtl/fpu_op_sequencer_pkg.sv
// fpu_pkg: definitions shared by the FPU op sequencer and its bench.
//   - FPU op codes as carried in {bundle[19], bundle[10:8]}
//   - bit positions inside the 20-bit decoded control bundle
//   - sequencer state encoding
//   - bundle_op(): extracts the 4-bit FPU op code from a bundle
package fpu_pkg;

  // FPU op codes
  localparam logic [3:0] FSUB    = 4'd0;
  localparam logic [3:0] FADD    = 4'd1;
  localparam logic [3:0] FMUL    = 4'd2;
  localparam logic [3:0] FDIV    = 4'd3;
  localparam logic [3:0] FSGNJ   = 4'd4;
  localparam logic [3:0] FMINMAX = 4'd5;
  localparam logic [3:0] FSQRT   = 4'd6;
  localparam logic [3:0] FCMP    = 4'd7;
  localparam logic [3:0] FCVT_WS = 4'd8;
  localparam logic [3:0] FCVT_SW = 4'd9;
  localparam logic [3:0] FMADD   = 4'd10;
  localparam logic [3:0] FMSUB   = 4'd11;
  localparam logic [3:0] FNMSUB  = 4'd12;
  localparam logic [3:0] FNMADD  = 4'd13;

  // Bit positions in the decoded control bundle
  localparam int FPU_OP   = 19;
  localparam int RES_SEL  = 18;
  localparam int FREG_WE  = 15;
  localparam int REG_WE   = 4;
  localparam int ALUOP_LO = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // FPU op code = {bundle[19], bundle[10:8]}
  function automatic logic [3:0] bundle_op(input logic [19:0] bundle);
    return {bundle[FPU_OP], bundle[ALUOP_LO+2:ALUOP_LO]};
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if: all non-clock/reset signals of the FPU op sequencer.
//   issue_*      : decoded FPU-class instruction from the ID/EX register
//   flush        : pipeline redirect, kills the in-flight op
//   stall        : hold IF/ID/EX while an FPU op occupies EX
//   fpu_*        : start pulse / op / rounding mode to the datapath, result and flags back
//   wb_*         : valid/ready writeback handshake with captured result
//   fflags_*     : CSR clear and sticky accumulated exception flags
// Modport slave is the sequencer; modport master is the surrounding pipeline.
interface fpu_op_sequencer_if;
  logic        issue_valid;
  logic [19:0] issue_signals;
  logic [2:0]  issue_rm;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;
  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_freg;
  logic        wb_xreg;
  logic        fflags_clr;
  logic [4:0]  fflags_acc;

  modport slave (
    input  issue_valid, issue_signals, issue_rm, issue_rd, flush,
    input  fpu_result, fpu_flags, wb_ready, fflags_clr,
    output stall, fpu_start, fpu_op, fpu_rm,
    output wb_valid, wb_data, wb_rd, wb_freg, wb_xreg, fflags_acc
  );

  modport master (
    output issue_valid, issue_signals, issue_rm, issue_rd, flush,
    output fpu_result, fpu_flags, wb_ready, fflags_clr,
    input  stall, fpu_start, fpu_op, fpu_rm,
    input  wb_valid, wb_data, wb_rd, wb_freg, wb_xreg, fflags_acc
  );
endinterface

// File: rtl/fpu_op_sequencer_lat_lut.sv
// fpu_lat_lut: combinational FPU op code -> datapath latency in cycles.
//   op_i  : 4-bit FPU op code
//   lat_o : latency (every LAT_* must be in 1..31)
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 14,
  parameter int LAT_FMA  = 5,
  parameter int LAT_MISC = 1
) (
  input  logic [3:0] op_i,
  output logic [4:0] lat_o
);

  // latency selection per op class
  always_comb begin
    lat_o = 5'(LAT_MISC);
    case (op_i)
      FADD, FSUB:                    lat_o = 5'(LAT_ADD);
      FMUL:                          lat_o = 5'(LAT_MUL);
      FDIV:                          lat_o = 5'(LAT_DIV);
      FSQRT:                         lat_o = 5'(LAT_SQRT);
      FMADD, FMSUB, FNMSUB, FNMADD:  lat_o = 5'(LAT_FMA);
      default:                       lat_o = 5'(LAT_MISC);
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues FPU-class instructions to a multi-cycle datapath,
// times their latency, stalls the pipeline, and hands the result to writeback.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fpu_op_sequencer_if.slave (issue, flush, stall, FPU, writeback, fflags)
// Flow: IDLE accepts (start pulse) -> EXEC counts LAT cycles and samples the
// datapath result -> WB holds wb_valid until wb_ready. flush returns to IDLE
// from any state without writing or accumulating flags.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 14,
  parameter int LAT_FMA  = 5,
  parameter int LAT_MISC = 1
) (
  input logic              clk,
  input logic              rst,
  fpu_op_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  rm_q, rm_d;
  logic [4:0]  rd_q, rd_d;
  logic        freg_q, freg_d;
  logic        xreg_q, xreg_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  flags_q, flags_d;
  logic [4:0]  acc_q, acc_d;

  logic        is_fpu_s;
  logic        accept_s;
  logic        retire_s;
  logic [3:0]  issue_op_s;
  logic [4:0]  lat_s;

  assign is_fpu_s   = bus.issue_valid & bus.issue_signals[RES_SEL];
  assign issue_op_s = bundle_op(bus.issue_signals);
  // Gated by rst so that the combinational outputs are also 0 during reset.
  assign accept_s   = ~rst & (state_q == ST_IDLE) & is_fpu_s & ~bus.flush;
  // flush beats wb_ready: a flushed result is neither written nor accumulated.
  assign retire_s   = (state_q == ST_WB) & bus.wb_ready & ~bus.flush;

  fpu_lat_lut #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_FMA (LAT_FMA),
    .LAT_MISC(LAT_MISC)
  ) u_lat (
    .op_i (issue_op_s),
    .lat_o(lat_s)
  );

  // next-state and datapath capture logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    freg_d  = freg_q;
    xreg_d  = xreg_q;
    data_d  = data_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = issue_op_s;
          rm_d    = bus.issue_rm;
          rd_d    = bus.issue_rd;
          freg_d  = bus.issue_signals[FREG_WE];
          xreg_d  = bus.issue_signals[REG_WE];
          // cnt reaches 0 in the LAT-th cycle after the start cycle
          cnt_d   = lat_s - 5'd1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 5'd0) begin
          data_d  = bus.fpu_result;
          flags_d = bus.fpu_flags;
          state_d = ST_WB;
        end else begin
          cnt_d   = cnt_q - 5'd1;
        end
      end
      ST_WB: begin
        if (bus.flush || bus.wb_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sticky flag accumulation: clear first, then OR in a retiring op's flags
  always_comb begin
    acc_d = bus.fflags_clr ? 5'd0 : acc_q;
    if (retire_s) begin
      acc_d = acc_d | flags_q;
    end else begin
      acc_d = acc_d;
    end
  end

  // state and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      rm_q    <= 3'd0;
      rd_q    <= 5'd0;
      freg_q  <= 1'b0;
      xreg_q  <= 1'b0;
      data_q  <= 32'd0;
      flags_q <= 5'd0;
      acc_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      freg_q  <= freg_d;
      xreg_q  <= xreg_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      acc_q   <= acc_d;
    end
  end

  // The instruction leaves EX in the same cycle its result is accepted.
  assign bus.stall      = ~rst & is_fpu_s & ~retire_s;
  assign bus.fpu_start  = accept_s;
  assign bus.fpu_op     = accept_s ? issue_op_s : op_q;
  assign bus.fpu_rm     = rm_q;
  assign bus.wb_valid   = (state_q == ST_WB);
  assign bus.wb_data    = data_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_freg    = freg_q;
  assign bus.wb_xreg    = xreg_q;
  assign bus.fflags_acc = acc_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: self-checking bench for fpu_op_sequencer.
// Reference model: an op starts in cycle 0, the result/flags present on the
// FPU bus in cycle LAT(op) are what writeback sees, wb_valid is up from cycle
// LAT+1 until wb_ready, and fflags_acc is a sticky OR of retired flags.
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] exp_acc;

  always #5 clk = ~clk;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic int ref_lat(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3;
    if (op == 4'd2) return 4;
    if (op == 4'd3) return 12;
    if (op == 4'd6) return 14;
    if (op >= 4'd10 && op <= 4'd13) return 5;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid   = 1'b0;
    bus.issue_signals = 20'd0;
    bus.issue_rm      = 3'd0;
    bus.issue_rd      = 5'd0;
    bus.flush         = 1'b0;
    bus.wb_ready      = 1'b0;
    bus.fflags_clr    = 1'b0;
    bus.fpu_result    = 32'd0;
    bus.fpu_flags     = 5'd0;
  endtask

  // One FPU op through start, EXEC, optional flush, WB with back-pressure.
  task automatic run_op(input logic [19:0] bnd, input logic [2:0] rm, input logic [4:0] rd,
                        input int ready_delay, input int flush_at, input logic clr_hs,
                        input logic fixed, input logic [31:0] fres, input logic [4:0] fflg);
    logic [3:0]  op;
    int          lat;
    logic [31:0] r;
    logic [4:0]  f;
    logic [31:0] exp_res;
    logic [4:0]  exp_flg;
    op = {bnd[19], bnd[10:8]};
    lat = ref_lat(op);
    exp_res = 32'd0;
    exp_flg = 5'd0;
    bus.issue_valid   = 1'b1;
    bus.issue_signals = bnd;
    bus.issue_rm      = rm;
    bus.issue_rd      = rd;
    bus.flush         = 1'b0;
    bus.wb_ready      = 1'b0;
    bus.fflags_clr    = 1'b0;
    bus.fpu_result    = fixed ? fres : 32'($urandom);
    bus.fpu_flags     = fixed ? fflg : 5'($urandom);
    #1;
    checks++;
    if ({bus.fpu_start, bus.stall, bus.wb_valid} !== 3'b110) begin
      errors++;
      $display("FAIL start_cycle op=%0d: got start/stall/valid=%b expected 110", op,
               {bus.fpu_start, bus.stall, bus.wb_valid});
    end
    checks++;
    if (bus.fpu_op !== op) begin
      errors++;
      $display("FAIL start_op: got %0d expected %0d", bus.fpu_op, op);
    end
    for (int c = 1; c <= lat; c++) begin
      tick();
      r = fixed ? fres : 32'($urandom);
      f = fixed ? fflg : 5'($urandom);
      bus.fpu_result = r;
      bus.fpu_flags  = f;
      if (c == lat) begin
        exp_res = r;
        exp_flg = f;
      end
      if (c == flush_at) begin
        bus.flush       = 1'b1;
        bus.issue_valid = 1'b0;
      end
      #1;
      checks++;
      if ({bus.fpu_start, bus.stall, bus.wb_valid} !== {1'b0, (c != flush_at), 1'b0}) begin
        errors++;
        $display("FAIL exec_ctrl op=%0d c=%0d: got start/stall/valid=%b expected %b", op, c,
                 {bus.fpu_start, bus.stall, bus.wb_valid}, {1'b0, (c != flush_at), 1'b0});
      end
      checks++;
      if ({bus.fpu_op, bus.fpu_rm} !== {op, rm}) begin
        errors++;
        $display("FAIL exec_op_rm c=%0d: got %h expected %h", c, {bus.fpu_op, bus.fpu_rm}, {op, rm});
      end
      if (c == flush_at) begin
        tick();
        bus.flush = 1'b0;
        #1;
        checks++;
        if ({bus.fpu_start, bus.stall, bus.wb_valid} !== 3'b000) begin
          errors++;
          $display("FAIL after_flush: got start/stall/valid=%b expected 000",
                   {bus.fpu_start, bus.stall, bus.wb_valid});
        end
        checks++;
        if (bus.fflags_acc !== exp_acc) begin
          errors++;
          $display("FAIL flush_acc: got %b expected %b", bus.fflags_acc, exp_acc);
        end
        return;
      end
    end
    for (int w = 0; w <= ready_delay; w++) begin
      tick();
      bus.fpu_result = 32'($urandom);
      bus.fpu_flags  = 5'($urandom);
      bus.wb_ready   = (w == ready_delay);
      bus.fflags_clr = clr_hs && (w == ready_delay);
      #1;
      checks++;
      if ({bus.fpu_start, bus.stall, bus.wb_valid} !== {1'b0, (w != ready_delay), 1'b1}) begin
        errors++;
        $display("FAIL wb_ctrl op=%0d w=%0d: got start/stall/valid=%b expected %b", op, w,
                 {bus.fpu_start, bus.stall, bus.wb_valid}, {1'b0, (w != ready_delay), 1'b1});
      end
      checks++;
      if ({bus.wb_data, bus.wb_rd, bus.wb_freg, bus.wb_xreg} !== {exp_res, rd, bnd[15], bnd[4]}) begin
        errors++;
        $display("FAIL wb_payload op=%0d: got %h expected %h", op,
                 {bus.wb_data, bus.wb_rd, bus.wb_freg, bus.wb_xreg}, {exp_res, rd, bnd[15], bnd[4]});
      end
      checks++;
      if (bus.fflags_acc !== exp_acc) begin
        errors++;
        $display("FAIL wb_acc_early: got %b expected %b", bus.fflags_acc, exp_acc);
      end
    end
    exp_acc = (clr_hs ? 5'd0 : exp_acc) | exp_flg;
    tick();
    drive_idle();
    #1;
    checks++;
    if ({bus.stall, bus.wb_valid} !== 2'b00) begin
      errors++;
      $display("FAIL post_wb: got stall/valid=%b expected 00", {bus.stall, bus.wb_valid});
    end
    checks++;
    if (bus.fflags_acc !== exp_acc) begin
      errors++;
      $display("FAIL acc_after_wb op=%0d: got %b expected %b", op, bus.fflags_acc, exp_acc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    exp_acc = 5'd0;
    #2;
    checks++;
    if ({bus.stall, bus.fpu_start, bus.fpu_op, bus.fpu_rm, bus.wb_valid, bus.wb_data, bus.wb_rd,
         bus.wb_freg, bus.wb_xreg, bus.fflags_acc} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs wb_data=%h acc=%b", bus.wb_data, bus.fflags_acc);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.stall, bus.fpu_start, bus.wb_valid, bus.fflags_acc} !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 0", {bus.stall, bus.fpu_start, bus.wb_valid, bus.fflags_acc});
    end
  endtask

  task automatic test_fadd();
    run_op(20'h78100, 3'd0, 5'd5, 0, -1, 1'b0, 1'b1, 32'h40400000, 5'd0);
  endtask

  task automatic test_fdiv();
    run_op(20'h48300, 3'd1, 5'd7, 0, -1, 1'b0, 1'b1, 32'h3F000000, 5'b01000);
    checks++;
    if (bus.fflags_acc !== 5'b01000) begin
      errors++;
      $display("FAIL fdiv_flags: got %b expected 01000", bus.fflags_acc);
    end
  endtask

  task automatic test_fcvt_backpressure();
    run_op(20'hD0010, 3'd1, 5'd12, 3, -1, 1'b0, 1'b0, 32'd0, 5'd0);
  endtask

  task automatic test_flush();
    // FSQRT killed at EXEC cnt=5 (cycle LAT-5 after start)
    run_op(20'h48600, 3'd2, 5'd3, 0, 9, 1'b0, 1'b1, 32'hDEADBEEF, 5'b11111);
    // flush in IDLE suppresses acceptance
    bus.issue_valid = 1'b1;
    bus.issue_signals = 20'h78100;
    bus.flush = 1'b1;
    #1;
    checks++;
    if ({bus.fpu_start, bus.stall} !== 2'b01) begin
      errors++;
      $display("FAIL idle_flush: got start/stall=%b expected 01", {bus.fpu_start, bus.stall});
    end
    tick();
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_flush_novalid: got %b expected 0", bus.wb_valid);
      end
    end
    // flush in WB beats wb_ready
    bus.issue_valid = 1'b1;
    bus.issue_signals = 20'h78100;
    bus.fpu_flags = 5'b11111;
    for (int i = 0; i < 4; i++) tick();
    bus.flush = 1'b1;
    bus.wb_ready = 1'b1;
    #1;
    checks++;
    if ({bus.wb_valid, bus.stall} !== 2'b11) begin
      errors++;
      $display("FAIL wb_flush: got valid/stall=%b expected 11", {bus.wb_valid, bus.stall});
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if ({bus.wb_valid, bus.fflags_acc} !== {1'b0, exp_acc}) begin
      errors++;
      $display("FAIL wb_flush_after: got %b expected %b", {bus.wb_valid, bus.fflags_acc}, {1'b0, exp_acc});
    end
  endtask

  task automatic test_flags();
    bus.fflags_clr = 1'b1;
    tick();
    bus.fflags_clr = 1'b0;
    exp_acc = 5'd0;
    checks++;
    if (bus.fflags_acc !== 5'd0) begin
      errors++;
      $display("FAIL idle_clr: got %b expected 00000", bus.fflags_acc);
    end
    run_op(20'h48200, 3'd0, 5'd1, 1, -1, 1'b0, 1'b1, 32'h1, 5'b00001);
    run_op(20'h78100, 3'd0, 5'd2, 0, -1, 1'b0, 1'b1, 32'h2, 5'b10000);
    checks++;
    if (bus.fflags_acc !== 5'b10001) begin
      errors++;
      $display("FAIL acc_or: got %b expected 10001", bus.fflags_acc);
    end
    run_op(20'h78100, 3'd0, 5'd3, 2, -1, 1'b1, 1'b1, 32'h3, 5'b00100);
    checks++;
    if (bus.fflags_acc !== 5'b00100) begin
      errors++;
      $display("FAIL clr_with_acc: got %b expected 00100", bus.fflags_acc);
    end
  endtask

  task automatic test_random();
    logic [19:0] b;
    logic [3:0]  op;
    int          fl;
    for (int i = 0; i < 26; i++) begin
      op = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      b = 20'($urandom);
      b[18] = 1'b1;
      b[19] = op[3];
      b[10:8] = op[2:0];
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ref_lat(op)) : -1;
      run_op(b, 3'($urandom), 5'($urandom), $urandom_range(0, 3), fl,
             ($urandom_range(0, 3) == 0), 1'b0, 32'd0, 5'd0);
    end
  endtask

  task automatic test_non_fpu();
    bus.issue_valid = 1'b1;
    bus.issue_signals = 20'h00210;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.fpu_start, bus.stall, bus.wb_valid} !== 3'b000) begin
        errors++;
        $display("FAIL non_fpu: got start/stall/valid=%b expected 000", {bus.fpu_start, bus.stall, bus.wb_valid});
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    bus.issue_valid = 1'b1;
    bus.issue_signals = 20'hC8200;
    bus.issue_rm = 3'd2;
    bus.issue_rd = 5'd9;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.fpu_start, bus.fpu_op, bus.fpu_rm, bus.wb_valid, bus.wb_data, bus.wb_rd,
         bus.wb_freg, bus.wb_xreg, bus.fflags_acc} !== 56'd0) begin
      errors++;
      $display("FAIL async_reset: got stall=%b op=%0d rm=%0d data=%h acc=%b", bus.stall, bus.fpu_op,
               bus.fpu_rm, bus.wb_data, bus.fflags_acc);
    end
    exp_acc = 5'd0;
    tick();
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({bus.stall, bus.wb_valid} !== 2'b00) begin
        errors++;
        $display("FAIL post_async_reset: got stall/valid=%b expected 00", {bus.stall, bus.wb_valid});
      end
    end
    run_op(20'hC8200, 3'd4, 5'd10, 1, -1, 1'b0, 1'b0, 32'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fdiv();
    test_fcvt_backpressure();
    test_flush();
    test_flags();
    test_random();
    test_non_fpu();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
